// File: rtl/matrix_mult_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the 3x3 matrix multiplier: sizes, FSM states and
// the helpers that map matrix coordinates onto the packed input/output buses.
package matrix_mult_pkg;

  localparam int N = 3;   // matrix order
  localparam int W = 8;   // element width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } rc_t;

  // Inputs pack element (r,c) LSB-first: (0,0) sits in the low byte.
  function automatic int in_off(input logic [1:0] r, input logic [1:0] c);
    return (int'(r) * N + int'(c)) * W;
  endfunction

  // The result bus packs element (r,c) MSB-first: returns the top bit of the
  // element, to be used with a descending (-:) part-select.
  function automatic int out_off(input logic [1:0] r, input logic [1:0] c);
    return N * N * W - 1 - W * (int'(r) * N + int'(c));
  endfunction

  // Row-major element index 0..8 to (row, col).
  function automatic rc_t idx_to_rc(input logic [3:0] idx);
    rc_t rc;
    case (idx)
      4'd0:    rc = '{row: 2'd0, col: 2'd0};
      4'd1:    rc = '{row: 2'd0, col: 2'd1};
      4'd2:    rc = '{row: 2'd0, col: 2'd2};
      4'd3:    rc = '{row: 2'd1, col: 2'd0};
      4'd4:    rc = '{row: 2'd1, col: 2'd1};
      4'd5:    rc = '{row: 2'd1, col: 2'd2};
      4'd6:    rc = '{row: 2'd2, col: 2'd0};
      4'd7:    rc = '{row: 2'd2, col: 2'd1};
      4'd8:    rc = '{row: 2'd2, col: 2'd2};
      default: rc = '{row: 2'd0, col: 2'd0};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/matrix_mult_dot3.sv
`timescale 1ns/1ps
// Combinational 3-term dot product of two W-bit vectors, truncated to W bits.
module matrix_mult_dot3
  import matrix_mult_pkg::*;
(
  input  logic [N*W-1:0] a_i,
  input  logic [N*W-1:0] b_i,
  output logic [W-1:0]   y_o
);

  // Evaluating in a W-bit context keeps exactly the low W bits of the
  // full-width sum, since truncation commutes with add and multiply mod 2^W.
  always_comb begin
    y_o = a_i[0*W +: W] * b_i[0*W +: W]
        + a_i[1*W +: W] * b_i[1*W +: W]
        + a_i[2*W +: W] * b_i[2*W +: W];
  end

endmodule

// File: rtl/matrix_mult.sv
`timescale 1ns/1ps
// 3x3 unsigned matrix multiplier: latches A and B, then produces one result
// element per cycle through a single shared dot-product unit.
module matrix_mult
  import matrix_mult_pkg::*;
(
  input  logic             Clock,
  input  logic             reset,
  input  logic             Enable,
  input  logic [N*N*W-1:0] A,
  input  logic [N*N*W-1:0] B,
  output logic [N*N*W-1:0] C,
  output logic             done
);

  state_e             state_q, state_d;
  logic [3:0]         idx_q,   idx_d;
  logic [N*N*W-1:0]   a_q,     a_d;
  logic [N*N*W-1:0]   b_q,     b_d;
  logic [N*N*W-1:0]   c_q,     c_d;
  logic               done_q,  done_d;

  rc_t                rc;
  logic [N*W-1:0]     a_vec, b_vec;
  logic [W-1:0]       dot;

  // Gather row rc.row of the latched A and column rc.col of the latched B.
  always_comb begin
    rc    = idx_to_rc(idx_q);
    a_vec = '0;
    b_vec = '0;
    for (int k = 0; k < N; k++) begin
      a_vec[k*W +: W] = a_q[in_off(rc.row, 2'(k)) +: W];
      b_vec[k*W +: W] = b_q[in_off(2'(k), rc.col) +: W];
    end
  end

  matrix_mult_dot3 u_dot3 (
    .a_i (a_vec),
    .b_i (b_vec),
    .y_o (dot)
  );

  // Next-state and datapath update for the IDLE/CALC/DONE controller.
  always_comb begin
    // NOTE: every target gets a hold-value default first so no path through
    // the case statement leaves a variable unassigned (which would infer a latch).
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (Enable) begin
          a_d     = A;
          b_d     = B;
          c_d     = '0;
          idx_d   = 4'd0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (!Enable) begin
          // Abort: the partially written result is left in place.
          done_d  = 1'b0;
          state_d = IDLE;
        end else begin
          c_d[out_off(rc.row, rc.col) -: W] = dot;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(N*N-1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Enable held high only holds the result; a restart needs IDLE first.
        if (!Enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: the latched operands are wide data registers, but they are still
    // reset here because a cleared operand state is part of the block's
    // defined reset behaviour, not just the control path.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign C    = c_q;
  assign done = done_q;

endmodule

// File: tb/tb_matrix_mult.sv
`timescale 1ns/1ps
// Self-checking bench for matrix_mult: directed cases plus random operands
// compared against a plain-arithmetic matrix product model.
module tb_matrix_mult;

  logic        Clock = 1'b0;
  logic        reset;
  logic        Enable;
  logic [71:0] A, B;
  logic [71:0] C;
  logic        done;

  int checks = 0;
  int errors = 0;

  matrix_mult dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .A      (A),
    .B      (B),
    .C      (C),
    .done   (done)
  );

  always #5 Clock = ~Clock;

  // Reference product: unpack both matrices, multiply with integer
  // arithmetic, keep each sum modulo 256, pack the result MSB-first.
  function automatic logic [71:0] ref_mul(input logic [71:0] a, input logic [71:0] b);
    int am [3][3];
    int bm [3][3];
    int sum;
    logic [71:0] res;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        am[r][c] = int'(a[(r*3+c)*8 +: 8]);
        bm[r][c] = int'(b[(r*3+c)*8 +: 8]);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        sum = 0;
        for (int k = 0; k < 3; k++) sum += am[r][k] * bm[k][c];
        res[71-8*(r*3+c) -: 8] = 8'(sum % 256);
      end
    return res;
  endfunction

  // Keep only the first n row-major elements of a packed result.
  function automatic logic [71:0] keep_first(input logic [71:0] m, input int n);
    logic [71:0] res;
    res = '0;
    for (int e = 0; e < n; e++) res[71-8*e -: 8] = m[71-8*e -: 8];
    return res;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait edge-by-edge (sampling 1 ns after each edge) until done, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge Clock);
      #1;
      edges++;
    end while (!done && edges < 30);
  endtask

  // Apply operands with Enable and run to completion; returns edge count.
  task automatic run_op(input logic [71:0] a, input logic [71:0] b, output int edges);
    A      = a;
    B      = b;
    Enable = 1'b1;
    wait_done(edges);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int          edges;
    logic [71:0] a0, b0, held;
    logic [71:0] ident;

    reset  = 1'b1;
    Enable = 1'b0;
    A      = '0;
    B      = '0;
    ident  = 72'h01_00_00_00_01_00_00_00_01;

    // Reset for 100 ns with Enable asserted to show reset priority.
    #40;
    Enable = 1'b1;
    A      = {9{8'hAA}};
    B      = {9{8'h55}};
    #60;
    @(negedge Clock);
    check("reset_C", C, '0);
    check("reset_done", {71'd0, done}, 72'd0);
    Enable = 1'b0;
    reset  = 1'b0;
    step();
    step();
    check("idle_done", {71'd0, done}, 72'd0);
    check("idle_C", C, '0);

    // Known-answer product with latency measurement.
    run_op(72'h09_08_07_06_05_04_03_02_01, 72'h01_09_08_07_06_05_04_03_02, edges);
    check("kat_latency", 72'(edges), 72'd10);
    check("kat_C", C, 72'h24_2A_15_51_60_39_7E_96_5D);
    Enable = 1'b0;
    held   = C;
    step();
    check("kat_drop_done", {71'd0, done}, 72'd0);
    check("kat_drop_C_held", C, held);

    // Identity times B returns B in output packing.
    run_op(ident, 72'h01_09_08_07_06_05_04_03_02, edges);
    check("ident_latency", 72'(edges), 72'd10);
    check("ident_c00", {64'd0, C[71:64]}, 72'd2);
    check("ident_c01", {64'd0, C[63:56]}, 72'd3);
    check("ident_c22", {64'd0, C[7:0]},   72'd1);
    check("ident_full", C, ref_mul(ident, 72'h01_09_08_07_06_05_04_03_02));
    Enable = 1'b0;
    step();

    // Saturated operands wrap modulo 256.
    run_op({9{8'hFF}}, {9{8'hFF}}, edges);
    check("max_C", C, {9{8'd3}});

    // Hold Enable after done: no restart, result stable; then release.
    held = C;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_done", {71'd0, done}, 72'd1);
      check("hold_C", C, held);
    end
    Enable = 1'b0;
    step();
    check("hold_release_done", {71'd0, done}, 72'd0);
    check("hold_release_C", C, held);

    // Operands changed right after the latch edge must not matter.
    a0     = {$urandom, $urandom, $urandom};
    b0     = {$urandom, $urandom, $urandom};
    A      = a0;
    B      = b0;
    Enable = 1'b1;
    step();
    A = ~a0;
    B = {$urandom, $urandom, $urandom};
    wait_done(edges);
    check("latch_latency", 72'(edges), 72'd9);
    check("latch_C", C, ref_mul(a0, b0));
    Enable = 1'b0;
    step();

    // Abort in CALC after three elements were written.
    a0     = {$urandom, $urandom, $urandom};
    b0     = {$urandom, $urandom, $urandom};
    A      = a0;
    B      = b0;
    Enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("calc_done_low", {71'd0, done}, 72'd0);
    Enable = 1'b0;
    step();
    check("abort_done", {71'd0, done}, 72'd0);
    check("abort_partial_C", C, keep_first(ref_mul(a0, b0), 3));
    step();
    step();
    check("abort_still_idle", {71'd0, done}, 72'd0);
    check("abort_C_held", C, keep_first(ref_mul(a0, b0), 3));

    // Reset while in DONE clears result and flag immediately.
    a0 = {$urandom, $urandom, $urandom};
    b0 = {$urandom, $urandom, $urandom};
    run_op(a0, b0, edges);
    check("pre_reset_C", C, ref_mul(a0, b0));
    reset = 1'b1;
    step();
    check("rst_done_flag", {71'd0, done}, 72'd0);
    check("rst_done_C", C, '0);
    Enable = 1'b0;
    reset  = 1'b0;
    step();
    step();
    check("post_rst_idle_done", {71'd0, done}, 72'd0);
    check("post_rst_idle_C", C, '0);

    // Random operands against the model.
    for (int t = 0; t < 8; t++) begin
      a0 = {$urandom, $urandom, $urandom};
      b0 = {$urandom, $urandom, $urandom};
      run_op(a0, b0, edges);
      check("rand_latency", 72'(edges), 72'd10);
      check("rand_C", C, ref_mul(a0, b0));
      Enable = 1'b0;
      step();
      check("rand_release_done", {71'd0, done}, 72'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
